// File: rtl/jk_mod_counter_if.sv
// Control/data bundle for jk_mod_counter: requester drives mode/enable/operands,
// the counter returns its state, complement, terminal count and wrap pulse.
interface jk_mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             wrap;

  modport master (
    output en, mode, j, k, d,
    input  q, qbar, tc, wrap
  );

  modport slave (
    input  en, mode, j, k, d,
    output q, qbar, tc, wrap
  );
endinterface

// File: rtl/jk_mod_counter.sv
// WIDTH JK cells forming a register with raw JK, modulo up/down count and load
// modes; counting modes drive the cells through JK excitation of the next value.
module jk_mod_counter #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MODULUS   = 16,
  parameter int unsigned RESET_VAL = 0
) (
  input logic               clk,
  input logic               reset,
  jk_mod_counter_if.slave   bus
);

  localparam logic [1:0]       MODE_JK   = 2'b00;
  localparam logic [1:0]       MODE_UP   = 2'b01;
  localparam logic [1:0]       MODE_DOWN = 2'b10;
  localparam logic [1:0]       MODE_LOAD = 2'b11;
  localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] j_cell, k_cell;
  logic             out_of_range;

  // Unreachable when MODULUS == 2**WIDTH since q can never reach MOD_EXT.
  assign out_of_range = ({1'b0, q_q} >= MOD_EXT);

  // Next value selection and JK cell drive
  always_comb begin
    next_val = q_q;
    wrap_d   = 1'b0;
    j_cell   = '0;
    k_cell   = '0;
    if (bus.en) begin
      unique case (bus.mode)
        MODE_JK: begin
          j_cell = bus.j;
          k_cell = bus.k;
        end
        MODE_UP: begin
          if (out_of_range) begin
            next_val = '0;
          end else if (q_q == MAX_VAL) begin
            next_val = '0;
            wrap_d   = 1'b1;
          end else begin
            next_val = q_q + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (out_of_range) begin
            next_val = MAX_VAL;
          end else if (q_q == '0) begin
            next_val = MAX_VAL;
            wrap_d   = 1'b1;
          end else begin
            next_val = q_q - WIDTH'(1);
          end
        end
        MODE_LOAD: next_val = bus.d;
        default:   next_val = q_q;
      endcase
      if (bus.mode != MODE_JK) begin
        j_cell = ~q_q & next_val;
        k_cell = q_q & ~next_val;
      end
    end
  end

  // Per-bit JK cell: 00 hold, 01 clear, 10 set, 11 toggle
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      unique case ({j_cell[i], k_cell[i]})
        2'b00:   q_d[i] = q_q[i];
        2'b01:   q_d[i] = 1'b0;
        2'b10:   q_d[i] = 1'b1;
        default: q_d[i] = ~q_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q    <= WIDTH'(RESET_VAL);
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.qbar = ~q_q;
  assign bus.wrap = wrap_q;
  assign bus.tc   = bus.en & (((bus.mode == MODE_UP) & (q_q == MAX_VAL)) |
                              ((bus.mode == MODE_DOWN) & (q_q == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: MODULUS=10 instance for the main plan,
// plus a MODULUS=16/RESET_VAL=15 instance for full-range overflow.
module tb_jk_mod_counter;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic reset_a;
  logic reset_b;
  int   vec_cnt;
  int   err_cnt;

  jk_mod_counter_if #(.WIDTH(WIDTH)) bus_a ();
  jk_mod_counter_if #(.WIDTH(WIDTH)) bus_b ();

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(10), .RESET_VAL(0)) dut_a (
    .clk   (clk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(16), .RESET_VAL(15)) dut_b (
    .clk   (clk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int unsigned q_exp,
                         input int unsigned wrap_exp, input int unsigned tc_exp);
    check({tag, ".q"},    32'(bus_a.q),    q_exp);
    check({tag, ".wrap"}, 32'(bus_a.wrap), wrap_exp);
    check({tag, ".tc"},   32'(bus_a.tc),   tc_exp);
  endtask

  task automatic drive_a(input logic en, input logic [1:0] mode,
                         input logic [3:0] j, input logic [3:0] k, input logic [3:0] d);
    bus_a.en   = en;
    bus_a.mode = mode;
    bus_a.j    = j;
    bus_a.k    = k;
    bus_a.d    = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset_a = 1'b0;
    reset_b = 1'b1;
    drive_a(1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
    bus_b.en   = 1'b1;
    bus_b.mode = 2'b01;
    bus_b.j    = '0;
    bus_b.k    = '0;
    bus_b.d    = '0;

    // 1. Reset before any edge takes effect immediately
    #3 reset_a = 1'b1;
    #1;
    check("rst0.q",    32'(bus_a.q),    0);
    check("rst0.qbar", 32'(bus_a.qbar), 15);
    check("rst0.wrap", 32'(bus_a.wrap), 0);
    @(posedge clk);
    #1 reset_a = 1'b0;
    drive_a(1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    repeat (5) step();
    check("pre_mid.q", 32'(bus_a.q), 5);
    #2 reset_a = 1'b1;
    #1;
    check("mid_rst.q",    32'(bus_a.q),    0);
    check("mid_rst.qbar", 32'(bus_a.qbar), 15);
    #1 reset_a = 1'b0;
    step();
    check("post_rst.q", 32'(bus_a.q), 1);

    // 2. Up count through a full modulus from zero
    #2 reset_a = 1'b1;
    #1 reset_a = 1'b0;
    check("up0.tc", 32'(bus_a.tc), 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      check_a($sformatf("up%0d", i), i % 10, (i == 10) ? 1 : 0, (i == 9) ? 1 : 0);
    end

    // 3. Down count wraps from zero to MODULUS-1
    drive_a(1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    #1;
    check("dn0.tc", 32'(bus_a.tc), 1);
    step();
    check_a("dn1", 9, 1, 0);
    check("dn1.qbar", 32'(bus_a.qbar), 6);
    step();
    check_a("dn2", 8, 0, 0);

    // 4. Raw JK mode from 0101
    drive_a(1'b1, 2'b11, 4'h0, 4'h0, 4'h5);
    step();
    check_a("ld5", 5, 0, 0);
    drive_a(1'b1, 2'b00, 4'b1010, 4'b0101, 4'h0);
    #1;
    check("jk.tc", 32'(bus_a.tc), 0);
    step();
    check_a("jk_setclr", 10, 0, 0);
    check("jk_setclr.qbar", 32'(bus_a.qbar), 5);
    drive_a(1'b1, 2'b00, 4'b1111, 4'b1111, 4'h0);
    step();
    check_a("jk_tog", 5, 0, 0);
    drive_a(1'b1, 2'b00, 4'b0000, 4'b0000, 4'h0);
    step();
    check_a("jk_hold", 5, 0, 0);
    drive_a(1'b1, 2'b00, 4'b0000, 4'b1111, 4'h0);
    step();
    check_a("jk_clr", 0, 0, 0);

    // 5. Out-of-range load and recovery in both directions
    drive_a(1'b1, 2'b11, 4'h0, 4'h0, 4'hC);
    step();
    check_a("ld12", 12, 0, 0);
    drive_a(1'b1, 2'b01, 4'h0, 4'h0, 4'h0);
    #1;
    check("oor_up.tc", 32'(bus_a.tc), 0);
    step();
    check_a("oor_up", 0, 0, 0);
    drive_a(1'b1, 2'b11, 4'h0, 4'h0, 4'hC);
    step();
    check_a("ld12b", 12, 0, 0);
    drive_a(1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
    step();
    check_a("oor_dn", 9, 0, 0);

    // 6. Enable low holds q=9 and masks tc
    drive_a(1'b0, 2'b01, 4'hF, 4'hF, 4'h3);
    #1;
    check("en0.tc", 32'(bus_a.tc), 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_a($sformatf("en0_%0d", i), 9, 0, 0);
    end
    bus_a.en = 1'b1;
    #1;
    check("en1.tc", 32'(bus_a.tc), 1);

    // 6b. MODULUS=16 overflow from RESET_VAL=15
    check("b_rst.q", 32'(bus_b.q), 15);
    #1 reset_b = 1'b0;
    check("b_pre.tc", 32'(bus_b.tc), 1);
    step();
    check("b_wrap.q",    32'(bus_b.q),    0);
    check("b_wrap.wrap", 32'(bus_b.wrap), 1);
    check("b_wrap.tc",   32'(bus_b.tc),   0);
    step();
    check("b_next.q",    32'(bus_b.q),    1);
    check("b_next.wrap", 32'(bus_b.wrap), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
Parametrised synchronous register built from WIDTH JK flip-flop cells sharing one clock and one reset. Mode input selects one of four operations:
- raw per-bit JK operation
- modulo-MODULUS up count
- modulo-MODULUS down count
- parallel load

Serves as the general-purpose counter/state register for later sequential exercises. The tc output is cascadable.

Parameters:
WIDTH, 4, number of JK cells / bits of q
MODULUS, 16, count modulus for up/down modes; legal range 2..2**WIDTH
RESET_VAL, 0, value forced onto q by reset; must be < 2**WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
en  input  1  synchronous enable; 0 = hold
mode  input  2  00 JK, 01 up, 10 down, 11 load
j  input  WIDTH  per-bit J inputs (mode 00 only)
k  input  WIDTH  per-bit K inputs (mode 00 only)
d  input  WIDTH  parallel load data (mode 11 only)
q  output  WIDTH  register state
qbar  output  WIDTH  bitwise complement of q, always ~q
tc  output  1  terminal count, combinational
wrap  output  1  registered one-cycle pulse after a modulo wrap

Behaviour:
- Reset:
  - reset=1 forces q=RESET_VAL and wrap=0 immediately, without waiting for clk, and overrides every other input.
  - Reset asserted mid-count clears at once.
  - The first rising edge after deassertion operates normally.
- Storage structure:
  - Every bit is a JK cell: 00 hold, 01 clear, 10 set, 11 toggle.
  - In modes 01/10/11, the next value N is computed first. Cell inputs are then the excitation values j_i = ~q_i & N_i and k_i = q_i & ~N_i.
- en=0: q holds on every edge and wrap=0, regardless of mode/j/k/d.
- Mode 00 (JK): each bit follows the JK table using its own j[i], k[i]. The result is stored raw, with no modulus check. wrap=0.
- Mode 01 (up):
  - q < MODULUS-1: N = q+1, wrap=0.
  - q == MODULUS-1: N = 0, wrap=1.
  - q >= MODULUS (out of range via JK or load): N = 0, wrap=0. This is recovery, not a wrap.
- Mode 10 (down):
  - 0 < q < MODULUS: N = q-1, wrap=0.
  - q == 0: N = MODULUS-1, wrap=1.
  - q >= MODULUS: N = MODULUS-1, wrap=0.
- Mode 11 (load): N = d, stored raw even if d >= MODULUS. wrap=0.
- Arithmetic: all arithmetic is WIDTH bits, unsigned. MODULUS = 2**WIDTH must work with natural overflow, so that the out-of-range branch is unreachable.
- tc (combinational from current q, en, mode; no clock dependency):
  - tc = en & ((mode==01 & q==MODULUS-1) | (mode==10 & q==0)).
  - tc=0 in modes 00/11.
- wrap timing: asserted for exactly the one cycle following the edge that performed the wrap. Cleared on the next edge unless another wrap occurs (e.g. MODULUS=2 up-count gives wrap every second cycle).
- Latency: one clock from input to q/wrap. tc and qbar reflect q with zero cycles of added latency.
- Input changes between edges: no effect on q.
- X/Z inputs: not required to be handled.

Test Plan:
(WIDTH=4, MODULUS=10, RESET_VAL=0 unless noted)
1. Reset:
   - Assert reset at t=3 before any edge -> q=0000, qbar=1111, wrap=0 immediately.
   - Count up to q=5, raise reset between edges -> q=0 before the next edge.
   - Release -> next edge with mode=01 gives q=1.
2. Up count: en=1, mode=01 from q=0, 10 edges -> q runs 1..9, then 0.
   - tc=1 only while q=9.
   - wrap=1 only for the cycle after the 9->0 edge.
3. Down count: mode=10 from q=0 -> q=9 with tc=1 before the edge and wrap=1 after it; next edge q=8, wrap=0.
4. JK mode from q=0101:
   - j=1010, k=0101 -> 1010.
   - j=k=1111 -> 0101.
   - j=k=0000 -> 0101 held.
   - j=0000, k=1111 -> 0000.
5. Out-of-range:
   - mode=11, d=1100 -> q=12, wrap=0.
   - mode=01 -> q=0, wrap=0.
   - Reload 12, mode=10 -> q=9, wrap=0.
6. Enable and full-range overflow:
   - q=9, mode=01, en=0 for 3 edges -> q=9, tc=0, wrap=0.
   - Separately with MODULUS=16, RESET_VAL=15, mode=01 -> q=0, wrap=1.
